// File: rtl/multi_digit_entry.sv
// Keypad-style multi-digit entry register with a multiplexed 7-segment scanner.
// Optional macro MULTI_DIGIT_ENTRY_HEX_EN accepts and displays hex digits A..F.
module multi_digit_entry #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    clear,
    input  logic [3:0]              dataIn,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [3:0]              count,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              cathodes
);

    localparam int SCAN_W = $clog2(NUM_DIGITS);
    localparam int REF_W  = $clog2(REFRESH_DIV);

    localparam logic [REF_W-1:0]  REF_LAST   = REF_W'(REFRESH_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(NUM_DIGITS - 1);
    localparam logic [3:0]        COUNT_FULL = 4'(NUM_DIGITS);

    typedef logic [3:0] digit_t;

    digit_t                  digits [NUM_DIGITS];
    logic                    load_q;
    logic                    digit_legal;
    logic                    accept;
    logic [REF_W-1:0]        ref_cnt;
    logic [SCAN_W-1:0]       scan_idx;
    digit_t                  shown;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   anodes_d;
    logic [7:0]              cathodes_d;

    // Active-low segment patterns, dp off; codes outside the legal set stay dark.
    function automatic logic [7:0] glyph(input digit_t d);
        case (d)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
`ifdef MULTI_DIGIT_ENTRY_HEX_EN
            4'd10:   glyph = 8'h88;
            4'd11:   glyph = 8'h83;
            4'd12:   glyph = 8'hC6;
            4'd13:   glyph = 8'hA1;
            4'd14:   glyph = 8'h86;
            4'd15:   glyph = 8'h8E;
`endif
            default: glyph = 8'hFF;
        endcase
    endfunction

`ifdef MULTI_DIGIT_ENTRY_HEX_EN
    assign digit_legal = 1'b1;
`else
    assign digit_legal = (dataIn <= 4'd9);
`endif

    // A held load key enters one digit: only the rising edge is accepted.
    assign accept = load & ~load_q & digit_legal;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, which the digit shift below relies on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q <= 1'b0;
            count  <= 4'd0;
            // NOTE: the digit store is a handful of flops, not a RAM, so it is
            // safe (and required) to clear it on reset.
            for (int k = 0; k < NUM_DIGITS; k++) digits[k] <= '0;
        end else begin
            load_q <= load;
            if (clear) begin
                count <= 4'd0;
                for (int k = 0; k < NUM_DIGITS; k++) digits[k] <= '0;
            end else if (accept) begin
                digits[0] <= dataIn;
                for (int k = 1; k < NUM_DIGITS; k++) digits[k] <= digits[k-1];
                if (count != COUNT_FULL) count <= count + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt  <= '0;
            scan_idx <= (scan_idx == SCAN_LAST) ? '0 : scan_idx + SCAN_W'(1);
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    always_comb begin
        value = '0;
        for (int k = 0; k < NUM_DIGITS; k++) value[4*k +: 4] = digits[k];
    end

    // Leading unentered digits are blanked; digit 0 always shows something.
    always_comb begin
        // NOTE: defaults first so every path assigns every output: no latches.
        anodes_d   = '1;
        cathodes_d = 8'hFF;
        shown      = digits[scan_idx];
        blank      = (scan_idx != '0) && (4'(scan_idx) >= count);
        if (!blank) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                anodes_d[i] = (scan_idx != SCAN_W'(i));
            cathodes_d = glyph(shown);
            if (scan_idx == '0 && count == COUNT_FULL) cathodes_d[7] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anodes   <= '1;
            cathodes <= 8'hFF;
        end else begin
            anodes   <= anodes_d;
            cathodes <= cathodes_d;
        end
    end

endmodule

// File: tb/tb_multi_digit_entry.sv
// Directed self-checking bench for multi_digit_entry (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_multi_digit_entry;

    localparam int N  = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    dataIn = 4'd0;
    logic [4*N-1:0] value;
    logic [3:0]    count;
    logic [N-1:0]  anodes;
    logic [7:0]    cathodes;

    int vectors = 0;
    int miscompares = 0;

    // Expected scan position: which digit the registered outputs currently show.
    int ref_cnt;
    int scan;
    int disp_idx;

    logic [N-1:0] obs_an   [N];
    logic [7:0]   obs_cath [N];

    multi_digit_entry #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .clear    (clear),
        .dataIn   (dataIn),
        .value    (value),
        .count    (count),
        .anodes   (anodes),
        .cathodes (cathodes)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt  <= 0;
            scan     <= 0;
            disp_idx <= 0;
        end else begin
            disp_idx <= scan;
            if (ref_cnt == RD - 1) begin
                ref_cnt <= 0;
                scan    <= (scan + 1) % N;
            end else begin
                ref_cnt <= ref_cnt + 1;
            end
        end
    end

    task automatic capture_scan();
        for (int i = 0; i < N; i++) begin
            obs_an[i]   = 'x;
            obs_cath[i] = 'x;
        end
        repeat (RD * N) begin
            @(negedge clk);
            obs_an[disp_idx]   = anodes;
            obs_cath[disp_idx] = cathodes;
        end
    endtask

    task automatic enter_digit(input logic [3:0] d);
        @(negedge clk);
        dataIn = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] ea [N];
        logic [7:0]   ec [N];
        ea = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        ec = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (anodes !== 4'hF || cathodes !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_outputs: anodes=%b cathodes=%h, want 1111/ff", anodes, cathodes);
        end
        vectors++;
        if (value !== 16'h0000 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: value=%h count=%0d, want 0000/0", value, count);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (anodes !== 4'b1110 || cathodes !== 8'hC0) begin
            miscompares++;
            $display("FAIL release_first: anodes=%b cathodes=%h, want 1110/c0", anodes, cathodes);
        end
        capture_scan();
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (obs_an[k] !== ea[k] || obs_cath[k] !== ec[k]) begin
                miscompares++;
                $display("FAIL reset_scan digit %0d: anodes=%b cathodes=%h, want %b/%h",
                         k, obs_an[k], obs_cath[k], ea[k], ec[k]);
            end
        end
    endtask

    task automatic test_entry_123();
        logic [N-1:0] ea [N];
        logic [7:0]   ec [N];
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
        ec = '{8'hB0, 8'hA4, 8'hF9, 8'hFF};
        enter_digit(4'd1);
        enter_digit(4'd2);
        enter_digit(4'd3);
        vectors++;
        if (value !== 16'h0123 || count !== 4'd3) begin
            miscompares++;
            $display("FAIL entry_123: value=%h count=%0d, want 0123/3", value, count);
        end
        capture_scan();
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (obs_an[k] !== ea[k] || obs_cath[k] !== ec[k]) begin
                miscompares++;
                $display("FAIL entry_scan digit %0d: anodes=%b cathodes=%h, want %b/%h",
                         k, obs_an[k], obs_cath[k], ea[k], ec[k]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] ea [N];
        logic [7:0]   ec [N];
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        ec = '{8'h12, 8'h99, 8'hB0, 8'hA4};
        do_clear();
        vectors++;
        if (value !== 16'h0000 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL clear: value=%h count=%0d, want 0000/0", value, count);
        end
        for (int d = 1; d <= 5; d++) begin
            enter_digit(4'(d));
            if (d == 4) begin
                vectors++;
                if (value !== 16'h1234 || count !== 4'd4) begin
                    miscompares++;
                    $display("FAIL fill_4: value=%h count=%0d, want 1234/4", value, count);
                end
            end
        end
        vectors++;
        if (value !== 16'h2345 || count !== 4'd4) begin
            miscompares++;
            $display("FAIL overflow: value=%h count=%0d, want 2345/4", value, count);
        end
        capture_scan();
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (obs_an[k] !== ea[k] || obs_cath[k] !== ec[k]) begin
                miscompares++;
                $display("FAIL full_scan digit %0d: anodes=%b cathodes=%h, want %b/%h",
                         k, obs_an[k], obs_cath[k], ea[k], ec[k]);
            end
        end
    endtask

    task automatic test_load_held();
        do_clear();
        @(negedge clk);
        dataIn = 4'd7;
        load   = 1'b1;
        repeat (20) @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        vectors++;
        if (value !== 16'h0007 || count !== 4'd1) begin
            miscompares++;
            $display("FAIL load_held: value=%h count=%0d, want 0007/1", value, count);
        end
        dataIn = 4'd5;
        load   = 1'b1;
        clear  = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        vectors++;
        if (value !== 16'h0000 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL clear_wins: value=%h count=%0d, want 0000/0", value, count);
        end
        @(negedge clk);
        vectors++;
        if (value !== 16'h0000 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL edge_lost: value=%h count=%0d, want 0000/0", value, count);
        end
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hex();
        logic [15:0]  exp_value;
        logic [3:0]   exp_count;
        logic [N-1:0] exp_an1;
        logic [7:0]   exp_c0;
        logic [7:0]   exp_c1;
`ifdef MULTI_DIGIT_ENTRY_HEX_EN
        exp_value = 16'h009A;
        exp_count = 4'd2;
        exp_an1   = 4'b1101;
        exp_c0    = 8'h88;
        exp_c1    = 8'h90;
`else
        exp_value = 16'h0009;
        exp_count = 4'd1;
        exp_an1   = 4'b1111;
        exp_c0    = 8'h90;
        exp_c1    = 8'hFF;
`endif
        enter_digit(4'd9);
        vectors++;
        if (value !== 16'h0009 || count !== 4'd1) begin
            miscompares++;
            $display("FAIL enter_9: value=%h count=%0d, want 0009/1", value, count);
        end
        enter_digit(4'hA);
        vectors++;
        if (value !== exp_value || count !== exp_count) begin
            miscompares++;
            $display("FAIL hex_a: value=%h count=%0d, want %h/%0d", value, count, exp_value, exp_count);
        end
        capture_scan();
        vectors++;
        if (obs_an[0] !== 4'b1110 || obs_cath[0] !== exp_c0) begin
            miscompares++;
            $display("FAIL hex_digit0: anodes=%b cathodes=%h, want 1110/%h", obs_an[0], obs_cath[0], exp_c0);
        end
        vectors++;
        if (obs_an[1] !== exp_an1 || obs_cath[1] !== exp_c1) begin
            miscompares++;
            $display("FAIL hex_digit1: anodes=%b cathodes=%h, want %b/%h", obs_an[1], obs_cath[1], exp_an1, exp_c1);
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        enter_digit(4'd1);
        enter_digit(4'd2);
        enter_digit(4'd3);
        vectors++;
        if (count !== 4'd3) begin
            miscompares++;
            $display("FAIL pre_reset: count=%0d, want 3", count);
        end
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (anodes !== 4'hF || cathodes !== 8'hFF || value !== 16'h0000 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: anodes=%b cathodes=%h value=%h count=%0d, want 1111/ff/0000/0",
                     anodes, cathodes, value, count);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (anodes !== 4'b1110 || cathodes !== 8'hC0 || value !== 16'h0000 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL after_release: anodes=%b cathodes=%h value=%h count=%0d, want 1110/c0/0000/0",
                     anodes, cathodes, value, count);
        end
        capture_scan();
        for (int k = 1; k < N; k++) begin
            vectors++;
            if (obs_an[k] !== 4'b1111 || obs_cath[k] !== 8'hFF) begin
                miscompares++;
                $display("FAIL post_reset_scan digit %0d: anodes=%b cathodes=%h, want 1111/ff",
                         k, obs_an[k], obs_cath[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry_123();
        test_overflow();
        test_load_held();
        test_hex();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
